seq_multiplier_4bits: RTL and testbench

Sequential 4x4 unsigned shift-and-add multiplier that drives the team's 4-bit NOR-gate ripple adder (`FullAdder_4bits_in_nor`) and consumes its `sum`/`cout` every step. It sits directly downstream of that adder in the arithmetic lab datapath. The block accepts one operand pair per start pulse and returns an 8-bit product after four add/shift steps, with a busy/done handshake.

---
 rtl/seq_multiplier_4bits_pkg.sv | 13 +
 rtl/seq_multiplier_4bits_adder.sv | 30 +++
 rtl/seq_multiplier_4bits.sv | 80 ++++++++
 tb/tb_seq_multiplier_4bits.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/seq_multiplier_4bits_pkg.sv
// Shared constants and FSM state encoding for the sequential 4x4 shift-and-add multiplier.
package seq_multiplier_4bits_pkg;

    localparam int SIZE  = 4;
    localparam int STEPS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier_4bits_adder.sv
// 4-bit ripple-carry adder built purely from 2-input NOR gates (nine per bit).
module FullAdder_4bits_in_nor (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;
    logic [3:0] g1, g2, g3, g4, g5, g6, g7;

    assign carry[0] = cin;

    // g4 is XNOR(a,b); g5 is (a^b)&~cin, reused by both sum and carry.
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign g1[i]       = ~(a[i]  | b[i]);
        assign g2[i]       = ~(a[i]  | g1[i]);
        assign g3[i]       = ~(b[i]  | g1[i]);
        assign g4[i]       = ~(g2[i] | g3[i]);
        assign g5[i]       = ~(g4[i] | carry[i]);
        assign g6[i]       = ~(g4[i] | g5[i]);
        assign g7[i]       = ~(carry[i] | g5[i]);
        assign sum[i]      = ~(g6[i] | g7[i]);
        assign carry[i+1]  = ~(g1[i] | g5[i]);
    end

    assign cout = carry[4];

endmodule

// File: rtl/seq_multiplier_4bits.sv
// Sequential 4x4 unsigned shift-and-add multiplier with a busy/done handshake.
module seq_multiplier_4bits
    import seq_multiplier_4bits_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*SIZE-1:0] product
);

    state_t            state, next_state;
    logic [SIZE-1:0]   m;
    logic [2*SIZE-1:0] p;
    logic [2*SIZE-1:0] p_next;
    logic [1:0]        cnt;
    logic [SIZE-1:0]   add_sum;
    logic              add_cout;

    FullAdder_4bits_in_nor u_adder (
        .a    (p[2*SIZE-1:SIZE]),
        .b    (m),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The adder carry becomes the new MSB, so 15*15 never loses a bit.
    assign p_next = p[0] ? {add_cout, add_sum, p[SIZE-1:1]}
                         : {1'b0, p[2*SIZE-1:1]};

    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (cnt == 2'(STEPS - 1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m       <= '0;
            p       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= a;
                        p   <= {{SIZE{1'b0}}, b};
                        cnt <= '0;
                    end
                end
                CALC: begin
                    p   <= p_next;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'(STEPS - 1)) product <= p_next;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier_4bits.sv
// Directed bench for seq_multiplier_4bits: handshake timing, corner products, reset abort, sweep.
module tb_seq_multiplier_4bits;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int checks = 0;
    int errors = 0;

    seq_multiplier_4bits dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One operation with start pulsed for a single cycle; operands scrambled after capture.
    task automatic run_op(input logic [3:0] op_a, input logic [3:0] op_b,
                          input logic [7:0] exp, input bit full);
        @(negedge clk);
        a = op_a; b = op_b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~op_a; b = ~op_b;
        if (full) begin
            check("busy_after_k", busy, 1'b1);
            check("done_after_k", done, 1'b0);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (full) begin
                check("busy_calc", busy, 1'b1);
                check("done_calc", done, 1'b0);
            end
        end
        @(negedge clk);
        check("done_pulse", done, 1'b1);
        check("product", product, exp);
        if (full) check("busy_done", busy, 1'b1);
        @(negedge clk);
        if (full) begin
            check("busy_idle", busy, 1'b0);
            check("done_idle", done, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_product", product, 8'h00);
        rst_n = 1'b1;

        run_op(4'd13, 4'd11, 8'h8F, 1'b1);
        run_op(4'd15, 4'd15, 8'hE1, 1'b1);
        run_op(4'd0,  4'd9,  8'h00, 1'b1);

        // start held high; operands change mid-CALC.
        @(negedge clk);
        a = 4'd3; b = 4'd5; start = 1'b1;
        @(negedge clk);
        check("hold_busy_k", busy, 1'b1);
        @(negedge clk);
        a = 4'd7; b = 4'd7;
        for (int i = 0; i < 3; i++) begin
            check("hold_busy_calc", busy, 1'b1);
            check("hold_done_calc", done, 1'b0);
            @(negedge clk);
        end
        check("hold_done1", done, 1'b1);
        check("hold_product1", product, 8'h0F);
        @(negedge clk);
        check("hold_idle_k5", busy, 1'b0);
        check("hold_done_k5", done, 1'b0);
        @(negedge clk);
        check("hold_accept_k6", busy, 1'b1);
        check("hold_product_kept", product, 8'h0F);
        repeat (4) @(negedge clk);
        check("hold_done2", done, 1'b1);
        check("hold_product2", product, 8'h31);
        start = 1'b0;
        @(negedge clk);
        check("hold_idle_end", busy, 1'b0);

        // Asynchronous reset during step 2 of 9*9.
        @(negedge clk);
        a = 4'd9; b = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_product", product, 8'h00);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check("arst_no_done", done, 1'b0);
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_no_done", done, 1'b0);
        end
        run_op(4'd2, 4'd3, 8'h06, 1'b1);

        run_op(4'd6, 4'd7, 8'h2A, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_2a_product", product, 8'h2A);
            check("hold_2a_done", done, 1'b0);
        end

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_op(4'(i), 4'(j), 8'(i * j), 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
